particle_renderer: RTL and testbench
====================================

Name: particle_renderer

Overview:
- Reader for the particle state bus: snapshots the (x, y) positions of four particle instances once per frame.
- Rasterises the snapshot into a 16x16 one-bit framebuffer.
- Row-scans the framebuffer onto the 16x16 LED matrix.
- Sits between the particle/spring mesh and the matrix driver pins; the grid is the particles' 0..15 bounce box.

Parameters:
- ROW_CYCLES, 1000: clock cycles each row is held during scan; legal range >= 2.
- FLIP_Y, 1: 1 = particle y=15 drives matrix row 0 (y-up physics onto a top-down matrix); 0 = row index equals y.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-low reset (asserted when 0)
- x0,y0 .. x3,y3  input  32 each, signed  particle positions, integer grid units
- freeze  input  1  when 1 at snapshot time, the previous snapshot is kept
- row_sel  output  16  one-hot active-high row enable; bit r = matrix row r
- col_data  output  16  column pixels for the selected row; bit c = column x=c
- frame_done  output  1  one-cycle pulse on the last scan cycle of each frame
- busy_draw  output  1  high during CLEAR and PLOT phases

Behaviour:
- Reset (reset==0 at a clk edge):
  - row_sel=0, col_data=0, frame_done=0, busy_draw=1.
  - Snapshot registers=0; framebuffer contents don't care (CLEAR overwrites them).
  - Next state is CLEAR with row counter 0.
  - Reset mid-frame aborts immediately, with no partial frame_done.
- All outputs are registered and reflect the state entered on the preceding edge.
- Frame sequence; cycle k is the k-th edge after reset release:
  - CLEAR, k=0..15: fb[k] <= 0.
    - At k=0, x0..y3 are latched into the snapshot unless freeze==1.
    - row_sel=0, col_data=0, busy_draw=1.
  - PLOT, k=16..19: particle i=k-16 is plotted from the snapshot, one particle per cycle.
    - Plot condition: 0<=x<=15 and 0<=y<=15, compared as signed 32-bit. Out-of-range particles (negative, or >=16, including huge values) are skipped silently.
    - Pixel position: row = FLIP_Y ? 15-y : y; set bit x of fb[row]. Bits are ORed, so coincident particles give one lit pixel.
    - row_sel=0 throughout PLOT.
  - SCAN, k=20 .. 20+16*ROW_CYCLES-1: rows r=0..15 in order, each held ROW_CYCLES cycles.
    - row_sel = 1<<r, col_data = fb[r], busy_draw=0.
    - Hold counter counts 0..ROW_CYCLES-1, then advances r.
    - After r=15 completes, return to CLEAR with k restarting at 0 (next frame).
  - frame_done=1 for exactly the last SCAN cycle (r=15, hold=ROW_CYCLES-1).
- Frame period: 20+16*ROW_CYCLES cycles, constant and independent of inputs.
- Timing guarantees:
  - row_sel is never non-zero on more than one bit.
  - row_sel changes only at row boundaries and phase boundaries.
- Inputs are sampled only at CLEAR k=0. Changes at any other time have no visible effect until the next frame.
- freeze:
  - Sampled only at CLEAR k=0.
  - Does not stop CLEAR/PLOT, so the frozen snapshot is redrawn identically every frame.
- Counters:
  - Hold counter width is $clog2(ROW_CYCLES).
  - Phase/row counters are 5 bits.
  - All counters wrap only by explicit reload, never by overflow.

Test Plan (ROW_CYCLES=4, FLIP_Y=1 unless noted; frame = 84 cycles):
- Reset low 3 cycles, then high with all particles at (0,0) -> row_sel=0 for cycles 0..19; cycles 20..75 col_data=0; row 15 (cycles 80..83) row_sel=16'h8000, col_data=16'h0001; frame_done high only at cycle 83; next frame CLEAR starts at cycle 84.
- Particles at (3,15),(3,15),(15,0),(7,8) -> row0 col_data=16'h0008, row7 =16'h0080, row15 =16'h8000; duplicate particle lights one pixel.
- FLIP_Y=0, particle0 at (5,2), others off-grid -> only row 2 shows 16'h0020.
- Particles at (-1,4),(16,4),(4,16),(32'h7FFFFFFF,0) -> every row col_data=0; frame_done still pulses once per 84 cycles.
- Frame 1 particle0 at (1,1); freeze=1 at frame-2 start while input moves to (9,9) -> frame 2 still shows only (1,1); freeze=0 at frame-3 start -> (9,9) appears. Changing inputs mid-SCAN never alters the current frame.
- Reset low at cycle 50 (mid SCAN) -> next edge row_sel=0, col_data=0, busy_draw=1, no frame_done; after release the full 84-cycle sequence restarts from CLEAR k=0.

Source files
------------

// File: rtl/particle_renderer.sv
// Snapshots four particle positions per frame, rasterises them into a 16x16
// one-bit framebuffer and row-scans the result onto an LED matrix.
module particle_renderer #(
   parameter int ROW_CYCLES = 1000,
   parameter bit FLIP_Y     = 1'b1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic signed [31:0] x0,
   input  logic signed [31:0] y0,
   input  logic signed [31:0] x1,
   input  logic signed [31:0] y1,
   input  logic signed [31:0] x2,
   input  logic signed [31:0] y2,
   input  logic signed [31:0] x3,
   input  logic signed [31:0] y3,
   input  logic               freeze,
   output logic [15:0]        row_sel,
   output logic [15:0]        col_data,
   output logic               frame_done,
   output logic               busy_draw
);

   localparam int HW = $clog2(ROW_CYCLES);
   localparam logic [HW-1:0] HOLD_LAST = HW'(ROW_CYCLES - 1);

   typedef enum logic [1:0] {ST_CLEAR, ST_PLOT, ST_SCAN} state_t;

   state_t             state_q, state_d;
   logic [4:0]         cnt_q, cnt_d;
   logic [HW-1:0]      hold_q, hold_d;
   logic [3:0][31:0]   snap_x_q, snap_x_d, snap_y_q, snap_y_d;
   logic [3:0][31:0]   in_x, in_y;
   logic [15:0][15:0]  fb_q, fb_d;
   logic [15:0]        row_sel_q, row_sel_d, col_data_q, col_data_d;
   logic               frame_done_q, frame_done_d, busy_draw_q, busy_draw_d;
   logic signed [31:0] px, py;
   logic [3:0]         plot_row;

   assign in_x = {x3, x2, x1, x0};
   assign in_y = {y3, y2, y1, y0};

   // State register
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= ST_CLEAR;
         cnt_q        <= '0;
         hold_q       <= '0;
         snap_x_q     <= '0;
         snap_y_q     <= '0;
         row_sel_q    <= '0;
         col_data_q   <= '0;
         frame_done_q <= 1'b0;
         busy_draw_q  <= 1'b1;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         hold_q       <= hold_d;
         snap_x_q     <= snap_x_d;
         snap_y_q     <= snap_y_d;
         row_sel_q    <= row_sel_d;
         col_data_q   <= col_data_d;
         frame_done_q <= frame_done_d;
         busy_draw_q  <= busy_draw_d;
      end
   end

   // Framebuffer needs no reset: CLEAR rewrites every row before SCAN.
   always_ff @(posedge clk) begin
      fb_q <= fb_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hold_d  = hold_q;
      case (state_q)
         ST_CLEAR: begin
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd15) begin
               state_d = ST_PLOT;
               cnt_d   = '0;
            end
         end
         ST_PLOT: begin
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd3) begin
               state_d = ST_SCAN;
               cnt_d   = '0;
               hold_d  = '0;
            end
         end
         ST_SCAN: begin
            if (hold_q == HOLD_LAST) begin
               hold_d = '0;
               if (cnt_q == 5'd15) begin
                  state_d = ST_CLEAR;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 5'd1;
               end
            end else begin
               hold_d = hold_q + HW'(1);
            end
         end
         default: begin
            state_d = ST_CLEAR;
            cnt_d   = '0;
            hold_d  = '0;
         end
      endcase
   end

   // Snapshot and framebuffer update
   always_comb begin
      snap_x_d = snap_x_q;
      snap_y_d = snap_y_q;
      fb_d     = fb_q;
      px       = $signed(snap_x_q[cnt_q[1:0]]);
      py       = $signed(snap_y_q[cnt_q[1:0]]);
      plot_row = FLIP_Y ? (4'd15 - py[3:0]) : py[3:0];
      if (state_q == ST_CLEAR) begin
         fb_d[cnt_q[3:0]] = '0;
         if (cnt_q == 5'd0 && !freeze) begin
            snap_x_d = in_x;
            snap_y_d = in_y;
         end
      end else if (state_q == ST_PLOT) begin
         if (px >= 0 && px <= 32'sd15 && py >= 0 && py <= 32'sd15)
            fb_d[plot_row][px[3:0]] = 1'b1;
      end
   end

   // Outputs are decoded from the next state (and next framebuffer, so the
   // last PLOT write is visible to row 0) and then registered.
   always_comb begin
      row_sel_d    = '0;
      col_data_d   = '0;
      busy_draw_d  = 1'b1;
      frame_done_d = 1'b0;
      if (state_d == ST_SCAN) begin
         row_sel_d    = 16'd1 << cnt_d[3:0];
         col_data_d   = fb_d[cnt_d[3:0]];
         busy_draw_d  = 1'b0;
         frame_done_d = (cnt_d == 5'd15) && (hold_d == HOLD_LAST);
      end
   end

   assign row_sel    = row_sel_q;
   assign col_data   = col_data_q;
   assign frame_done = frame_done_q;
   assign busy_draw  = busy_draw_q;

endmodule

// File: tb/tb_particle_renderer.sv
// Directed bench for particle_renderer: two instances (FLIP_Y=1 and 0) share
// inputs; each scenario checks every cycle of a full 84-cycle frame.
module tb_particle_renderer;

   logic               clk = 1'b0;
   logic               reset;
   logic signed [31:0] x0, y0, x1, y1, x2, y2, x3, y3;
   logic               freeze;
   logic [15:0]        row_sel_f, col_data_f, row_sel_n, col_data_n;
   logic               frame_done_f, busy_draw_f, frame_done_n, busy_draw_n;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   particle_renderer #(.ROW_CYCLES(4), .FLIP_Y(1'b1)) dut_flip (
      .clk(clk), .reset(reset),
      .x0(x0), .y0(y0), .x1(x1), .y1(y1), .x2(x2), .y2(y2), .x3(x3), .y3(y3),
      .freeze(freeze),
      .row_sel(row_sel_f), .col_data(col_data_f),
      .frame_done(frame_done_f), .busy_draw(busy_draw_f)
   );

   particle_renderer #(.ROW_CYCLES(4), .FLIP_Y(1'b0)) dut_noflip (
      .clk(clk), .reset(reset),
      .x0(x0), .y0(y0), .x1(x1), .y1(y1), .x2(x2), .y2(y2), .x3(x3), .y3(y3),
      .freeze(freeze),
      .row_sel(row_sel_n), .col_data(col_data_n),
      .frame_done(frame_done_n), .busy_draw(busy_draw_n)
   );

   task automatic set_p(input int i, input logic signed [31:0] px, input logic signed [31:0] py);
      case (i)
         0: begin x0 = px; y0 = py; end
         1: begin x1 = px; y1 = py; end
         2: begin x2 = px; y2 = py; end
         default: begin x3 = px; y3 = py; end
      endcase
   endtask

   // Called at the negedge where cycle 0 is visible; returns at the next frame's cycle 0.
   task automatic run_frame(input string name,
                            input logic [15:0][15:0] ef,
                            input logic [15:0][15:0] en,
                            input bit mid_move,
                            input logic signed [31:0] mx,
                            input logic signed [31:0] my);
      logic [15:0] ers, ecf, ecn;
      logic        efd, ebz;
      for (int k = 0; k < 84; k++) begin
         if (mid_move && k == 50) set_p(0, mx, my);
         if (k < 20) begin
            ers = '0; ecf = '0; ecn = '0; ebz = 1'b1;
         end else begin
            ers = 16'd1 << ((k - 20) / 4);
            ecf = ef[(k - 20) / 4];
            ecn = en[(k - 20) / 4];
            ebz = 1'b0;
         end
         efd = (k == 83);
         n_checks += 8;
         if (row_sel_f !== ers) begin
            n_fail++; $display("FAIL %s k=%0d flip row_sel got %h exp %h", name, k, row_sel_f, ers);
         end
         if (col_data_f !== ecf) begin
            n_fail++; $display("FAIL %s k=%0d flip col_data got %h exp %h", name, k, col_data_f, ecf);
         end
         if (frame_done_f !== efd) begin
            n_fail++; $display("FAIL %s k=%0d flip frame_done got %b exp %b", name, k, frame_done_f, efd);
         end
         if (busy_draw_f !== ebz) begin
            n_fail++; $display("FAIL %s k=%0d flip busy_draw got %b exp %b", name, k, busy_draw_f, ebz);
         end
         if (row_sel_n !== ers) begin
            n_fail++; $display("FAIL %s k=%0d noflip row_sel got %h exp %h", name, k, row_sel_n, ers);
         end
         if (col_data_n !== ecn) begin
            n_fail++; $display("FAIL %s k=%0d noflip col_data got %h exp %h", name, k, col_data_n, ecn);
         end
         if (frame_done_n !== efd) begin
            n_fail++; $display("FAIL %s k=%0d noflip frame_done got %b exp %b", name, k, frame_done_n, efd);
         end
         if (busy_draw_n !== ebz) begin
            n_fail++; $display("FAIL %s k=%0d noflip busy_draw got %b exp %b", name, k, busy_draw_n, ebz);
         end
         @(negedge clk);
      end
   endtask

   task automatic check_idle(input string name);
      n_checks += 4;
      if (row_sel_f !== 16'h0 || row_sel_n !== 16'h0) begin
         n_fail++; $display("FAIL %s row_sel got %h/%h exp 0000", name, row_sel_f, row_sel_n);
      end
      if (col_data_f !== 16'h0 || col_data_n !== 16'h0) begin
         n_fail++; $display("FAIL %s col_data got %h/%h exp 0000", name, col_data_f, col_data_n);
      end
      if (frame_done_f !== 1'b0 || frame_done_n !== 1'b0) begin
         n_fail++; $display("FAIL %s frame_done got %b/%b exp 0", name, frame_done_f, frame_done_n);
      end
      if (busy_draw_f !== 1'b1 || busy_draw_n !== 1'b1) begin
         n_fail++; $display("FAIL %s busy_draw got %b/%b exp 1", name, busy_draw_f, busy_draw_n);
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      freeze = 1'b0;
      for (int i = 0; i < 4; i++) set_p(i, 0, 0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_idle("reset");
      reset = 1'b1;
   endtask

   task automatic test_origin();
      logic [15:0][15:0] ef, en;
      ef = '0; en = '0;
      ef[15] = 16'h0001;
      en[0]  = 16'h0001;
      run_frame("origin", ef, en, 1'b0, 0, 0);
   endtask

   task automatic test_plot();
      logic [15:0][15:0] ef, en;
      set_p(0, 3, 15); set_p(1, 3, 15); set_p(2, 15, 0); set_p(3, 7, 8);
      ef = '0; en = '0;
      ef[0] = 16'h0008; ef[7] = 16'h0080; ef[15] = 16'h8000;
      en[15] = 16'h0008; en[8] = 16'h0080; en[0] = 16'h8000;
      run_frame("plot", ef, en, 1'b0, 0, 0);
   endtask

   task automatic test_noflip();
      logic [15:0][15:0] ef, en;
      set_p(0, 5, 2); set_p(1, -1, 0); set_p(2, 20, 3); set_p(3, 0, -5);
      ef = '0; en = '0;
      en[2]  = 16'h0020;
      ef[13] = 16'h0020;
      run_frame("noflip", ef, en, 1'b0, 0, 0);
   endtask

   task automatic test_out_of_range();
      set_p(0, -1, 4); set_p(1, 16, 4); set_p(2, 4, 16); set_p(3, 32'sh7FFFFFFF, 0);
      run_frame("out_of_range", '0, '0, 1'b0, 0, 0);
   endtask

   task automatic test_freeze();
      logic [15:0][15:0] ef, en;
      set_p(0, 1, 1); set_p(1, -1, -1); set_p(2, -1, -1); set_p(3, -1, -1);
      ef = '0; en = '0;
      ef[14] = 16'h0002; en[1] = 16'h0002;
      run_frame("freeze_f1", ef, en, 1'b1, 9, 9);
      freeze = 1'b1;
      run_frame("freeze_f2", ef, en, 1'b0, 0, 0);
      freeze = 1'b0;
      ef = '0; en = '0;
      ef[6] = 16'h0200; en[9] = 16'h0200;
      run_frame("freeze_f3", ef, en, 1'b1, 2, 2);
   endtask

   task automatic test_reset_mid();
      logic [15:0][15:0] ef, en;
      for (int k = 0; k < 50; k++) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check_idle("reset_mid");
      reset = 1'b1;
      ef = '0; en = '0;
      ef[13] = 16'h0004; en[2] = 16'h0004;
      run_frame("after_reset", ef, en, 1'b0, 0, 0);
   endtask

   initial begin
      test_reset();
      test_origin();
      test_plot();
      test_noflip();
      test_out_of_range();
      test_freeze();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
